// File: rtl/note_pitch2dds_poly.sv
// Polyphonic note/pitch -> DDS increment converter: scans CHANNELS voices, shares one
// note->adder table and interpolates linearly between adjacent semitones for pitch bend.
module note_pitch2dds_poly #(
  parameter int CHANNELS   = 8,
  parameter int ACC_W      = 32,
  parameter int BEND_RANGE = 2,
  parameter int TABLE_LAT  = 1,
  localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [7*CHANNELS-1:0]     note,
  input  logic [14*CHANNELS-1:0]    pitch,
  input  logic                      refresh,
  output logic [6:0]                tbl_note,
  input  logic [ACC_W-1:0]          tbl_adder,
  output logic [ACC_W*CHANNELS-1:0] adder,
  output logic                      upd_valid,
  output logic [CH_W-1:0]           upd_ch,
  output logic                      busy
);

  localparam int PW = ACC_W + 9;
  localparam int SW = ACC_W + 10;
  localparam logic [1:0] WAIT_INIT = 2'((TABLE_LAT > 1) ? TABLE_LAT - 2 : 0);

  typedef enum logic [2:0] {
    S_SCAN = 3'd0,
    S_REQ0 = 3'd1,
    S_REQ1 = 3'd2,
    S_WAIT = 3'd3,
    S_ACC0 = 3'd4,
    S_ACC1 = 3'd5,
    S_WR   = 3'd6
  } state_t;

  state_t            state;
  logic [CH_W-1:0]   ptr;
  logic [CH_W-1:0]   ptr_next;
  logic              ptr_last;
  logic              refresh_pend;
  logic              armed;
  logic [1:0]        wait_cnt;
  logic [ACC_W-1:0]  a0;
  logic [ACC_W-1:0]  a1;

  logic [6:0]        sh_note  [CHANNELS];
  logic [13:0]       sh_pitch [CHANNELS];
  logic [ACC_W-1:0]  adder_r  [CHANNELS];

  logic [6:0]        cur_note;
  logic [13:0]       cur_pitch;
  logic              changed;
  logic              force_pass;

  logic signed [14:0] c;
  logic signed [19:0] off;
  logic signed [8:0]  hi;
  logic signed [8:0]  s;
  logic [7:0]         lo;
  logic [6:0]         n0;
  logic [6:0]         n1;
  logic [8:0]         w0;
  logic [8:0]         w1;
  logic [PW-1:0]      p0;
  logic [PW-1:0]      p1;
  logic [SW-1:0]      sum;
  logic [ACC_W-1:0]   result;

  assign busy     = (state != S_SCAN);
  assign ptr_last = (ptr == CH_W'(CHANNELS - 1));
  assign ptr_next = ptr_last ? '0 : ptr + 1'b1;

  always_comb begin
    cur_note   = note[7*ptr +: 7];
    cur_pitch  = pitch[14*ptr +: 14];
    changed    = (cur_note != sh_note[ptr]) || (cur_pitch != sh_pitch[ptr]);
    // A refresh only starts forcing at channel 0, so one request yields one full ordered pass.
    force_pass = armed || ((ptr == '0) && refresh_pend);
  end

  always_comb begin
    c   = $signed({1'b0, sh_pitch[ptr]}) - 15'sd8192;
    off = 20'(c) * 20'(BEND_RANGE);
    hi  = 9'(off >>> 13);
    lo  = 8'(off[12:0] >> 5);
    s   = $signed({2'b00, sh_note[ptr]}) + hi;
    n0  = s[6:0];
    if (s < 9'sd0) begin
      n0 = '0;
      lo = '0;
    end else if (s > 9'sd127) begin
      n0 = 7'd127;
      lo = '0;
    end
    n1 = (n0 == 7'd127) ? 7'd127 : n0 + 7'd1;
  end

  always_comb begin
    w1     = {1'b0, lo};
    w0     = 9'd256 - w1;
    p0     = PW'(a0) * PW'(w0);
    p1     = PW'(a1) * PW'(w1);
    sum    = SW'(p0) + SW'(p1);
    result = ACC_W'(sum >> 8);
  end

  always_comb begin
    adder = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      adder[ACC_W*k +: ACC_W] = adder_r[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_SCAN;
      ptr          <= '0;
      refresh_pend <= 1'b0;
      armed        <= 1'b0;
      wait_cnt     <= '0;
      tbl_note     <= '0;
      upd_valid    <= 1'b0;
      upd_ch       <= '0;
      a0           <= '0;
      a1           <= '0;
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        sh_note[k]  <= '0;
        sh_pitch[k] <= 14'd8192;
        adder_r[k]  <= '0;
      end
    end else begin
      upd_valid <= 1'b0;
      case (state)
        S_SCAN: begin
          if (changed || force_pass) begin
            sh_note[ptr]  <= cur_note;
            sh_pitch[ptr] <= cur_pitch;
            state         <= S_REQ0;
            if ((ptr == '0) && refresh_pend) armed <= 1'b1;
          end else begin
            ptr <= ptr_next;
            if (ptr_last && armed) begin
              armed        <= 1'b0;
              refresh_pend <= 1'b0;
            end
          end
        end
        S_REQ0: begin
          tbl_note <= n0;
          state    <= S_REQ1;
        end
        S_REQ1: begin
          tbl_note <= n1;
          wait_cnt <= WAIT_INIT;
          state    <= (TABLE_LAT > 1) ? S_WAIT : S_ACC0;
        end
        S_WAIT: begin
          if (wait_cnt == '0) state <= S_ACC0;
          else wait_cnt <= wait_cnt - 2'd1;
        end
        S_ACC0: begin
          a0    <= tbl_adder;
          state <= S_ACC1;
        end
        S_ACC1: begin
          a1    <= tbl_adder;
          state <= S_WR;
        end
        S_WR: begin
          adder_r[ptr] <= result;
          upd_valid    <= 1'b1;
          upd_ch       <= ptr;
          ptr          <= ptr_next;
          state        <= S_SCAN;
          if (ptr_last && armed) begin
            armed        <= 1'b0;
            refresh_pend <= 1'b0;
          end
        end
        default: state <= S_SCAN;
      endcase
      if (refresh) refresh_pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_note_pitch2dds_poly.sv
// Scoreboard bench for note_pitch2dds_poly with a note*1024 table delayed by TABLE_LAT.
module tb_note_pitch2dds_poly;

  localparam int CH   = 8;
  localparam int AW   = 32;
  localparam int BR   = 2;
  localparam int TL   = 1;
  localparam int CH_W = $clog2(CH);

  logic                 clk;
  logic                 rst_n;
  logic [7*CH-1:0]      note;
  logic [14*CH-1:0]     pitch;
  logic                 refresh;
  logic [6:0]           tbl_note;
  logic [AW-1:0]        tbl_adder;
  logic [AW*CH-1:0]     adder;
  logic                 upd_valid;
  logic [CH_W-1:0]      upd_ch;
  logic                 busy;

  typedef struct {
    logic [CH_W-1:0] ch;
    logic [AW-1:0]   val;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [AW-1:0] mon_slot;
  int          checks;
  int          errors;
  int          total_upd;
  int          upd_cnt [CH];
  int          cur_n   [CH];
  int          cur_p   [CH];
  logic [AW-1:0] tbl_pipe [TL];

  note_pitch2dds_poly #(
    .CHANNELS  (CH),
    .ACC_W     (AW),
    .BEND_RANGE(BR),
    .TABLE_LAT (TL)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .note     (note),
    .pitch    (pitch),
    .refresh  (refresh),
    .tbl_note (tbl_note),
    .tbl_adder(tbl_adder),
    .adder    (adder),
    .upd_valid(upd_valid),
    .upd_ch   (upd_ch),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    tbl_pipe[0] <= AW'({tbl_note, 10'b0});
    for (int i = 1; i < TL; i++) tbl_pipe[i] <= tbl_pipe[i-1];
  end
  assign tbl_adder = tbl_pipe[TL-1];

  function automatic logic [AW-1:0] model(input int n, input int p);
    int off, hi, lo, s, n0, n1;
    longint a0, a1;
    off = (p - 8192) * BR;
    hi  = off / 8192;
    if (off < 0 && (off % 8192) != 0) hi = hi - 1;
    lo  = (off - hi * 8192) / 32;
    s   = n + hi;
    if (s < 0) begin
      n0 = 0; lo = 0;
    end else if (s > 127) begin
      n0 = 127; lo = 0;
    end else begin
      n0 = s;
    end
    n1 = (n0 < 127) ? n0 + 1 : 127;
    a0 = longint'(n0) * 1024;
    a1 = longint'(n1) * 1024;
    return AW'((a0 * (256 - lo) + a1 * lo) / 256);
  endfunction

  task automatic drive_ch(input int ch, input int n, input int p);
    note[7*ch +: 7]   = 7'(n);
    pitch[14*ch +: 14] = 14'(p);
    cur_n[ch] = n;
    cur_p[ch] = p;
  endtask

  task automatic set_ch(input int ch, input int n, input int p, input logic [AW-1:0] ev);
    exp_t e;
    drive_ch(ch, n, p);
    e.ch  = CH_W'(ch);
    e.val = ev;
    sb.push_back(e);
  endtask

  task automatic wait_drain(input string name);
    int i;
    i = 0;
    while (sb.size() != 0 && i < 400) begin
      @(negedge clk);
      i++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d updates outstanding, required 0", name, sb.size());
      sb.delete();
    end
    repeat (4*CH + TL + 8) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && upd_valid === 1'b1) begin
      total_upd++;
      upd_cnt[upd_ch]++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_update: ch=%0d adder=%0d, required no update", upd_ch, adder[upd_ch*AW +: AW]);
      end else begin
        mon_e = sb.pop_front();
        if (upd_ch !== mon_e.ch) begin
          errors++;
          $display("FAIL upd_ch: got %0d, expected %0d", upd_ch, mon_e.ch);
        end
        checks++;
        mon_slot = adder[mon_e.ch*AW +: AW];
        if (mon_slot !== mon_e.val) begin
          errors++;
          $display("FAIL adder_value ch%0d: got %0d, expected %0d", mon_e.ch, mon_slot, mon_e.val);
        end
      end
    end
  end

  task automatic test_reset();
    int pulses;
    repeat (3) @(negedge clk);
    checks++;
    if (tbl_note !== 7'd0 || upd_valid !== 1'b0 || upd_ch !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: tbl_note=%0d upd_valid=%b upd_ch=%0d busy=%b, expected 0 0 0 0",
               tbl_note, upd_valid, upd_ch, busy);
    end
    checks++;
    if (adder !== '0) begin
      errors++;
      $display("FAIL reset_adders: got %h, expected all zero", adder);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    pulses = 0;
    repeat (4*CH) begin
      @(negedge clk);
      if (upd_valid === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL idle_updates: got %0d pulses, expected 0", pulses);
    end
    checks++;
    if (adder !== '0) begin
      errors++;
      $display("FAIL idle_adders: got %h, expected all zero", adder);
    end
  endtask

  task automatic test_latency();
    int  k;
    bit  seen;
    @(posedge clk); #1;
    set_ch(0, 60, 8192, 32'd61440);
    seen = 0;
    for (int i = 0; i < 4*CH && !seen; i++) begin
      @(negedge clk);
      if (busy === 1'b1) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL busy_start: busy=%b after %0d cycles, expected 1", busy, 4*CH);
    end
    k = 0;
    seen = 0;
    while (!seen && k < 4*TL + 20) begin
      @(negedge clk);
      k++;
      if (upd_valid === 1'b1) seen = 1;
    end
    checks++;
    if (!seen || k != TL + 4) begin
      errors++;
      $display("FAIL latency: got %0d cycles (seen=%0d), expected %0d", k, seen, TL + 4);
    end
    wait_drain("latency");
  endtask

  task automatic test_bend();
    @(posedge clk); #1;
    set_ch(3, 60, 16383, 32'd63484);
    wait_drain("bend_up");
    @(posedge clk); #1;
    set_ch(3, 60, 0, 32'd59392);
    wait_drain("bend_down");
  endtask

  task automatic test_clamps();
    @(posedge clk); #1;
    set_ch(2, 127, 16383, 32'd130048);
    wait_drain("clamp_high");
    @(posedge clk); #1;
    set_ch(2, 1, 0, 32'd0);
    wait_drain("clamp_low");
    @(posedge clk); #1;
    set_ch(2, 0, 4096, 32'd0);
    wait_drain("clamp_zero");
  endtask

  task automatic test_random();
    int ch, n, p;
    for (int i = 0; i < 6; i++) begin
      ch = $urandom_range(CH - 1, 4);
      n  = $urandom_range(127, 0);
      p  = $urandom_range(16383, 0);
      if (n == cur_n[ch] && p == cur_p[ch]) p = p ^ 1;
      @(posedge clk); #1;
      set_ch(ch, n, p, model(n, p));
      wait_drain("random");
    end
  endtask

  task automatic test_back_to_back();
    bit seen;
    int c1, c5;
    @(posedge clk); #1;
    set_ch(0, 40, 8192, model(40, 8192));
    seen = 0;
    for (int i = 0; i < 4*CH + 20 && !seen; i++) begin
      @(negedge clk);
      if (upd_valid === 1'b1 && upd_ch === CH_W'(0)) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL b2b_sync: ch0 update not seen, expected one");
    end
    c1 = upd_cnt[1];
    c5 = upd_cnt[5];
    set_ch(1, 72, 10000, model(72, 10000));
    set_ch(5, 50, 3000, model(50, 3000));
    @(posedge clk);
    @(posedge clk); #1;
    set_ch(1, 30, 12000, model(30, 12000));
    wait_drain("back_to_back");
    checks++;
    if (upd_cnt[1] - c1 != 2 || upd_cnt[5] - c5 != 1) begin
      errors++;
      $display("FAIL b2b_counts: ch1 %0d ch5 %0d updates, expected 2 and 1",
               upd_cnt[1] - c1, upd_cnt[5] - c5);
    end
  endtask

  task automatic test_reset_abort();
    bit   seen;
    exp_t e;
    @(posedge clk); #1;
    drive_ch(4, 90, cur_p[4]);
    seen = 0;
    for (int i = 0; i < 4*CH && !seen; i++) begin
      @(negedge clk);
      if (busy === 1'b1) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL abort_busy: busy=%b, expected 1", busy);
    end
    repeat (TL + 1) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (upd_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_flags: upd_valid=%b busy=%b, expected 0 0", upd_valid, busy);
    end
    checks++;
    if (adder !== '0) begin
      errors++;
      $display("FAIL abort_adders: got %h, expected all zero", adder);
    end
    @(posedge clk);
    @(posedge clk); #1;
    for (int k = 0; k < CH; k++) begin
      if (cur_n[k] != 0 || cur_p[k] != 8192) begin
        e.ch  = CH_W'(k);
        e.val = model(cur_n[k], cur_p[k]);
        sb.push_back(e);
      end
    end
    rst_n = 1'b1;
    wait_drain("after_reset");
  endtask

  task automatic test_refresh();
    int   base;
    exp_t e;
    base = total_upd;
    @(posedge clk); #1;
    refresh = 1'b1;
    for (int k = 0; k < CH; k++) begin
      e.ch  = CH_W'(k);
      e.val = model(cur_n[k], cur_p[k]);
      sb.push_back(e);
    end
    @(posedge clk); #1;
    refresh = 1'b0;
    wait_drain("refresh");
    checks++;
    if (total_upd - base != CH) begin
      errors++;
      $display("FAIL refresh_count: got %0d updates, expected %0d", total_upd - base, CH);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks    = 0;
    errors    = 0;
    total_upd = 0;
    rst_n     = 1'b0;
    refresh   = 1'b0;
    note      = '0;
    pitch     = '0;
    for (int k = 0; k < CH; k++) begin
      upd_cnt[k] = 0;
      drive_ch(k, 0, 8192);
    end
    test_reset();
    test_latency();
    test_bend();
    test_clamps();
    test_random();
    test_back_to_back();
    test_reset_abort();
    test_refresh();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
